// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-port virtual-channel FWFT FIFOs with credit return and packet state tracking.
// Define VCBUF_OVF_DET_EN to build the sticky err_ovf overflow detector.
module vc_input_buffer #(
  parameter int FLIT_W = 16,
  parameter int VC_W = 1,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  localparam int NUM_VC = 2**VC_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_vld,
  input  logic [VC_W-1:0]          in_vc,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic [NUM_VC-1:0]        out_vld,
  output logic [NUM_VC*FLIT_W-1:0] out_flit,
  output logic [NUM_VC-1:0]        out_head,
  input  logic [NUM_VC-1:0]        out_pop,
  output logic [NUM_VC-1:0]        credit_out,
  output logic                     err_ovf
);
  typedef enum logic {IDLE, ACTIVE} state_e;
`ifdef VCBUF_OVF_DET_EN
  logic [NUM_VC-1:0] drop;
  logic ovf_q;
  always_ff @(posedge clk) ovf_q <= clr ? 1'b0 : ovf_q | (|drop);
  assign err_ovf = ovf_q;
`else
  assign err_ovf = 1'b0;
`endif
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              cr_q, hit, full, pop, wr;
    logic [FLIT_W-1:0] front;
    state_e            st_q, st_d;
    assign front = mem_q[rd_ptr_q];
    assign hit   = in_vld && in_vc == VC_W'(v);
    assign full  = cnt_q == (PTR_W+1)'(DEPTH);
    assign pop   = !clr && out_pop[v] && cnt_q != '0;
    // a full VC still accepts a write when the same cycle frees a slot
    assign wr    = !clr && hit && (!full || pop);
    assign out_vld[v]  = cnt_q != '0;
    assign out_flit[v*FLIT_W +: FLIT_W] = front;
    assign out_head[v] = out_vld[v] && front[FLIT_W-1] && st_q == IDLE;
    assign credit_out[v] = cr_q;
`ifdef VCBUF_OVF_DET_EN
    assign drop[v] = !clr && hit && full && !pop;
`endif
    always_comb begin
      st_d = !pop ? st_q : front[FLIT_W-2] ? IDLE : front[FLIT_W-1] ? ACTIVE : st_q;
    end
    always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= in_flit;
    end
    always_ff @(posedge clk) begin
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        cr_q     <= 1'b0;
        st_q     <= IDLE;
      end else begin
        if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_q + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
        cr_q  <= pop;
        st_q  <= st_d;
      end
    end
  end
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb_vc_input_buffer: directed and random checks of vc_input_buffer against a queue-based model.
module tb_vc_input_buffer;
  logic        clk = 1'b0;
  logic        clr, in_vld;
  logic [0:0]  in_vc;
  logic [15:0] in_flit;
  logic [1:0]  out_vld, out_head, out_pop, credit_out;
  logic [31:0] out_flit;
  logic        err_ovf;

  int n_chk = 0, n_fail = 0;

  logic [15:0] mq [2][$];
  bit          mst [2];
  logic [1:0]  mcred;
  logic        movf;

  vc_input_buffer dut (
    .clk(clk), .clr(clr), .in_vld(in_vld), .in_vc(in_vc), .in_flit(in_flit),
    .out_vld(out_vld), .out_flit(out_flit), .out_head(out_head), .out_pop(out_pop),
    .credit_out(credit_out), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_vld();
    return {mq[1].size() > 0, mq[0].size() > 0};
  endfunction

  function automatic logic [1:0] exp_head();
    logic [1:0] h;
    for (int i = 0; i < 2; i++) h[i] = mq[i].size() > 0 && mq[i][0][15] && !mst[i];
    return h;
  endfunction

  task automatic cycle(input logic c, input logic v, input logic [0:0] vc,
                       input logic [15:0] f, input logic [1:0] p);
    clr = c; in_vld = v; in_vc = vc; in_flit = f; out_pop = p;
    @(posedge clk);
    if (c) begin
      mq[0].delete(); mq[1].delete(); mst[0] = 0; mst[1] = 0; mcred = 0; movf = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit full, pk;
        logic [15:0] fr;
        full = mq[i].size() == 4;
        pk = p[i] && mq[i].size() > 0;
        if (pk) begin
          fr = mq[i].pop_front();
          if (fr[14]) mst[i] = 0;
          else if (fr[15]) mst[i] = 1;
        end
        if (v && vc == i) begin
          if (!full || pk) mq[i].push_back(f);
          else begin
`ifdef VCBUF_OVF_DET_EN
            movf = 1;
`endif
          end
        end
        mcred[i] = pk;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 16'hffff, 2'b11);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_chk++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL reset_vld: got %b exp 00", out_vld); end
      n_chk++; if (credit_out !== 2'b00) begin n_fail++; $display("FAIL reset_credit: got %b exp 00", credit_out); end
      n_chk++; if (out_head !== 2'b00) begin n_fail++; $display("FAIL reset_head: got %b exp 00", out_head); end
      n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", err_ovf); end
    end
  endtask

  task automatic test_packet();
    logic [15:0] pk [3] = '{16'h8001, 16'h0002, 16'h4003};
    foreach (pk[i]) cycle(0, 1, 1, pk[i], 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (out_flit[31:16] !== pk[i]) begin n_fail++; $display("FAIL pkt_flit%0d: got %h exp %h", i, out_flit[31:16], pk[i]); end
      n_chk++; if (out_head[1] !== (i == 0)) begin n_fail++; $display("FAIL pkt_head%0d: got %b exp %b", i, out_head[1], i == 0); end
      cycle(0, 0, 0, 0, 2'b10);
      n_chk++; if (credit_out !== 2'b10) begin n_fail++; $display("FAIL pkt_credit%0d: got %b exp 10", i, credit_out); end
    end
    n_chk++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL pkt_empty: got %b exp 00", out_vld); end
    cycle(0, 1, 1, 16'hc005, 0);
    n_chk++; if (credit_out !== 2'b00) begin n_fail++; $display("FAIL pkt_credit_end: got %b exp 00", credit_out); end
    n_chk++; if (out_head !== 2'b10) begin n_fail++; $display("FAIL pkt_idle_head: got %b exp 10", out_head); end
    cycle(0, 0, 0, 0, 2'b10);
  endtask

  task automatic test_overflow();
    logic [15:0] f;
    for (int i = 0; i < 5; i++) begin
      f = {2'b00, 14'($urandom)};
      cycle(0, 1, 0, f, 0);
    end
    cycle(0, 0, 0, 0, 0);
    n_chk++; if (err_ovf !== movf) begin n_fail++; $display("FAIL ovf_flag: got %b exp %b", err_ovf, movf); end
`ifdef VCBUF_OVF_DET_EN
    n_chk++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b exp 1", err_ovf); end
`else
    n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_off: got %b exp 0", err_ovf); end
`endif
    n_chk++; if (mq[0].size() !== 4) begin n_fail++; $display("FAIL ovf_model_depth: got %0d exp 4", mq[0].size()); end
    n_chk++; if (out_vld !== 2'b01) begin n_fail++; $display("FAIL ovf_vld: got %b exp 01", out_vld); end
  endtask

  task automatic test_full_wr_pop();
    logic ovf_before;
    ovf_before = movf;
    cycle(0, 1, 0, 16'h1234, 2'b01);
    n_chk++; if (credit_out !== 2'b01) begin n_fail++; $display("FAIL fwp_credit: got %b exp 01", credit_out); end
    n_chk++; if (err_ovf !== ovf_before) begin n_fail++; $display("FAIL fwp_ovf: got %b exp %b", err_ovf, ovf_before); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_vld[0] !== 1'b1 || out_flit[15:0] !== mq[0][0]) begin n_fail++; $display("FAIL fwp_drain%0d: got %b/%h exp 1/%h", i, out_vld[0], out_flit[15:0], mq[0][0]); end
      cycle(0, 0, 0, 0, 2'b01);
    end
    n_chk++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL fwp_empty: got %b exp 00", out_vld); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cycle(0, 1, 1'(i), {2'b00, 14'($urandom)}, 0);
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (out_flit !== {mq[1][0], mq[0][0]}) begin n_fail++; $display("FAIL b2b_flit%0d: got %h exp %h", i, out_flit, {mq[1][0], mq[0][0]}); end
      cycle(0, 0, 0, 0, 2'b11);
      n_chk++; if (credit_out !== 2'b11) begin n_fail++; $display("FAIL b2b_credit%0d: got %b exp 11", i, credit_out); end
    end
    cycle(0, 0, 0, 0, 2'b10);
    n_chk++; if (credit_out !== 2'b00) begin n_fail++; $display("FAIL empty_pop_credit: got %b exp 00", credit_out); end
    n_chk++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL empty_pop_vld: got %b exp 00", out_vld); end
    cycle(0, 1, 1, 16'h0abc, 0);
    n_chk++; if (out_flit[31:16] !== 16'h0abc) begin n_fail++; $display("FAIL empty_pop_ptr: got %h exp 0abc", out_flit[31:16]); end
    cycle(0, 0, 0, 0, 2'b10);
  endtask

  task automatic test_clr_mid();
    cycle(0, 1, 0, 16'h8011, 0);
    cycle(0, 1, 0, 16'h0012, 0);
    cycle(0, 1, 0, 16'h0013, 0);
    cycle(0, 0, 0, 0, 2'b01);
    n_chk++; if (out_head[0] !== 1'b0 || !mst[0]) begin n_fail++; $display("FAIL clr_pre_active: got head %b exp 0", out_head[0]); end
    cycle(1, 1, 0, 16'h8099, 2'b01);
    n_chk++; if (out_vld !== 2'b00) begin n_fail++; $display("FAIL clr_vld: got %b exp 00", out_vld); end
    n_chk++; if (credit_out !== 2'b00) begin n_fail++; $display("FAIL clr_credit: got %b exp 00", credit_out); end
    n_chk++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b exp 0", err_ovf); end
    cycle(0, 1, 0, 16'h8020, 0);
    n_chk++; if (out_head !== 2'b01 || out_flit[15:0] !== 16'h8020) begin n_fail++; $display("FAIL clr_idle: got %b/%h exp 01/8020", out_head, out_flit[15:0]); end
    cycle(0, 1, 0, 16'h4021, 2'b01);
    cycle(0, 0, 0, 0, 2'b01);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom));
      n_chk++; if (out_vld !== exp_vld()) begin n_fail++; $display("FAIL rnd_vld@%0d: got %b exp %b", n, out_vld, exp_vld()); end
      n_chk++; if (out_head !== exp_head()) begin n_fail++; $display("FAIL rnd_head@%0d: got %b exp %b", n, out_head, exp_head()); end
      n_chk++; if (credit_out !== mcred) begin n_fail++; $display("FAIL rnd_credit@%0d: got %b exp %b", n, credit_out, mcred); end
      n_chk++; if (err_ovf !== movf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b exp %b", n, err_ovf, movf); end
      for (int i = 0; i < 2; i++)
        if (mq[i].size() > 0) begin
          n_chk++; if (out_flit[i*16 +: 16] !== mq[i][0]) begin n_fail++; $display("FAIL rnd_flit%0d@%0d: got %h exp %h", i, n, out_flit[i*16 +: 16], mq[i][0]); end
        end
    end
  endtask

  initial begin
    clr = 1; in_vld = 0; in_vc = 0; in_flit = 0; out_pop = 0;
    test_reset();
    test_packet();
    test_overflow();
    test_full_wr_pop();
    test_back_to_back();
    test_clr_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
